// File: rtl/dsp_sys_arr_pkg.sv
// rtl/dsp_sys_arr_pkg.sv - shared types and constants for the systolic-array stream buffers
package dsp_sys_arr_pkg;

    typedef logic [31:0] word_t;

    localparam int AXIS_DEFAULT_DEPTH = 8;

    // Pointer width: address bits plus one wrap bit.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/axis_stream_fifo_if.sv
// rtl/axis_stream_fifo_if.sv - valid/ready stream bundle carrying BW lanes of DW-bit words plus last
interface axis_stream_fifo_if
    import dsp_sys_arr_pkg::*;
#(
    parameter int BW = 2,
    parameter int DW = $bits(word_t)
);
    logic                   valid;
    logic                   ready;
    logic [BW-1:0][DW-1:0]  stream;
    logic                   last;

    modport master (output valid, output stream, output last, input ready);
    modport slave  (input valid, input stream, input last, output ready);

endinterface

// File: rtl/axis_fifo_mem.sv
// rtl/axis_fifo_mem.sv - DEPTH x WIDTH register array, synchronous write, combinational read
module axis_fifo_mem #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 65
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/axis_stream_fifo.sv
// rtl/axis_stream_fifo.sv - FWFT stream FIFO with count/flags/flush; AXIS_PACKET_MODE_EN selects store-and-forward
module axis_stream_fifo
    import dsp_sys_arr_pkg::*;
#(
    parameter int BW        = 2,
    parameter int DW        = $bits(word_t),
    parameter int DEPTH     = AXIS_DEFAULT_DEPTH,
    parameter int AF_THRESH = DEPTH - 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    axis_stream_fifo_if.slave      in_s,
    axis_stream_fifo_if.master     out_m,
    output logic [$clog2(DEPTH):0] count,
    output logic                   almost_full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = ptr_w(DEPTH);
    localparam int MW = BW * DW + 1;
    localparam logic [PW-1:0] AF_LVL = PW'(AF_THRESH);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          full;
    logic          push;
    logic          pop;
    logic          out_valid;
    logic          out_last;
    logic          mem_we;
    logic [MW-1:0] mem_wdata;
    logic [MW-1:0] mem_rdata;

    assign count       = wr_ptr_q - rd_ptr_q;
    assign empty       = (wr_ptr_q == rd_ptr_q);
    assign full        = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign almost_full = (count >= AF_LVL);

    // in_ready looks only at registered state, so a full FIFO never passes through.
    assign in_s.ready = !full;
    assign push       = in_s.valid && !full;
    assign pop        = out_valid && out_m.ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    assign mem_we    = push && !flush;
    assign mem_wdata = {in_s.last, in_s.stream};

    axis_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (MW)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wr_ptr_q[AW-1:0]),
        .wdata (mem_wdata),
        .raddr (rd_ptr_q[AW-1:0]),
        .rdata (mem_rdata)
    );

    // Stale array contents are masked so an empty FIFO always presents zeros.
    assign out_last     = !empty && mem_rdata[MW-1];
    assign out_m.stream = empty ? '0 : mem_rdata[MW-2:0];
    assign out_m.last   = out_last;
    assign out_m.valid  = out_valid;

`ifdef AXIS_PACKET_MODE_EN
    logic [PW-1:0] pkt_cnt_q, pkt_cnt_d;
    logic          pkt_in;
    logic          pkt_out;

    assign pkt_in  = push && in_s.last;
    assign pkt_out = pop && out_last;

    always_comb begin
        pkt_cnt_d = pkt_cnt_q;
        if (flush) begin
            pkt_cnt_d = '0;
        end else if (pkt_in && !pkt_out) begin
            pkt_cnt_d = pkt_cnt_q + PW'(1);
        end else if (!pkt_in && pkt_out) begin
            pkt_cnt_d = pkt_cnt_q - PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_cnt_q <= '0;
        end else begin
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

    // Releasing on full keeps packets longer than DEPTH from deadlocking.
    assign out_valid = !empty && ((pkt_cnt_q != '0) || full);
`else
    assign out_valid = !empty;
`endif

endmodule

// File: tb/tb_axis_stream_fifo.sv
// tb/tb_axis_stream_fifo.sv - directed table and sequence bench for axis_stream_fifo (DEPTH=8, AF_THRESH=6)
module tb_axis_stream_fifo;

    localparam int DEPTH = 8;
`ifdef AXIS_PACKET_MODE_EN
    localparam bit PKT = 1'b1;
`else
    localparam bit PKT = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       flush;
    logic [3:0] count;
    logic       almost_full;
    logic       empty;

    axis_stream_fifo_if #(.BW(2), .DW(32)) in_if ();
    axis_stream_fifo_if #(.BW(2), .DW(32)) out_if ();

    axis_stream_fifo #(
        .BW        (2),
        .DW        (32),
        .DEPTH     (DEPTH),
        .AF_THRESH (6)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_s        (in_if),
        .out_m       (out_if),
        .count       (count),
        .almost_full (almost_full),
        .empty       (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [31:0] v;
        logic        il;
        logic        ordy;
        logic [3:0]  cnt;
        logic        emp;
        logic        af;
        logic        ir;
        logic        ov;
        logic [31:0] odat;
        logic        olast;
    } vec_t;

    typedef struct {
        logic [63:0] d;
        logic        l;
    } beat_t;

    vec_t  tbl[$];
    beat_t mq[$];
    int    mpkt;
    int    n_total;
    int    n_bad;

    function automatic logic [63:0] mk(input logic [31:0] v);
        return {v ^ 32'hA5A5_0000, v};
    endfunction

    function automatic logic mvalid_f();
        return (mq.size() > 0) && (!PKT || mpkt > 0 || mq.size() == DEPTH);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic add(input logic iv, input logic [31:0] v, input logic il, input logic ordy,
                       input logic [3:0] cnt, input logic emp, input logic af, input logic ir,
                       input logic ov, input logic [31:0] odat, input logic olast);
        vec_t e;
        e.iv = iv; e.v = v; e.il = il; e.ordy = ordy; e.cnt = cnt; e.emp = emp;
        e.af = af; e.ir = ir; e.ov = ov; e.odat = odat; e.olast = olast;
        tbl.push_back(e);
    endtask

    // One clock against the queue model: drive, compare, clock, update model.
    task automatic cyc(input logic iv, input logic [31:0] v, input logic il, input logic ordy, input logic fl);
        logic mv, p, q;
        in_if.valid  = iv;
        in_if.stream = mk(v);
        in_if.last   = il;
        out_if.ready = ordy;
        flush        = fl;
        mv = mvalid_f();
        chk("count", 64'(count), 64'(mq.size()));
        chk("out_valid", 64'(out_if.valid), 64'(mv));
        chk("in_ready", 64'(in_if.ready), 64'(mq.size() < DEPTH));
        if (mq.size() > 0) begin
            chk("out_stream", out_if.stream, mq[0].d);
            chk("out_last", 64'(out_if.last), 64'(mq[0].l));
        end
        @(posedge clk);
        if (fl) begin
            mq.delete();
            mpkt = 0;
        end else begin
            p = iv && (mq.size() < DEPTH);
            q = mv && ordy;
            if (q) begin
                if (mq[0].l) mpkt--;
                void'(mq.pop_front());
            end
            if (p) begin
                beat_t b;
                b.d = mk(v);
                b.l = il;
                mq.push_back(b);
                if (il) mpkt++;
            end
        end
        #1;
    endtask

    task automatic drain();
        for (int k = 0; k < 40 && mq.size() > 0; k++) cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        chk("drain_empty", 64'(empty), 64'd1);
    endtask

    initial begin
        int          idx;
        logic        acc;
        logic        ordy;
        logic        stall;
        logic [63:0] prev;

        n_total = 0;
        n_bad   = 0;
        mpkt    = 0;
        rst          = 1'b1;
        flush        = 1'b0;
        in_if.valid  = 1'b0;
        in_if.stream = '0;
        in_if.last   = 1'b0;
        out_if.ready = 1'b0;

        // Fill 0x1..0x8 (last on 0x8), offer 0x9 at full, then drain.
        for (int i = 0; i < 8; i++)
            add(1'b1, 32'(i + 1), i == 7, 1'b0, 4'(i), i == 0, i >= 6, 1'b1,
                PKT ? 1'b0 : (i > 0), (i > 0) ? 32'h1 : 32'h0, 1'b0);
        add(1'b1, 32'h9, 1'b0, 1'b0, 4'd8, 1'b0, 1'b1, 1'b0, 1'b1, 32'h1, 1'b0);
        for (int j = 0; j < 8; j++)
            add(1'b0, 32'h0, 1'b0, 1'b1, 4'(8 - j), 1'b0, (8 - j) >= 6, j > 0,
                1'b1, 32'(j + 1), j == 7);
        add(1'b0, 32'h0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);

        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_af", 64'(almost_full), 64'd0);
        chk("rst_out_valid", 64'(out_if.valid), 64'd0);
        chk("rst_in_ready", 64'(in_if.ready), 64'd1);
        chk("rst_out_stream", out_if.stream, 64'd0);
        chk("rst_out_last", 64'(out_if.last), 64'd0);
        rst = 1'b0;

        foreach (tbl[n]) begin
            in_if.valid  = tbl[n].iv;
            in_if.stream = mk(tbl[n].v);
            in_if.last   = tbl[n].il;
            out_if.ready = tbl[n].ordy;
            chk("tbl_count", 64'(count), 64'(tbl[n].cnt));
            chk("tbl_empty", 64'(empty), 64'(tbl[n].emp));
            chk("tbl_af", 64'(almost_full), 64'(tbl[n].af));
            chk("tbl_in_ready", 64'(in_if.ready), 64'(tbl[n].ir));
            chk("tbl_out_valid", 64'(out_if.valid), 64'(tbl[n].ov));
            chk("tbl_out_stream", out_if.stream, tbl[n].emp ? 64'd0 : mk(tbl[n].odat));
            chk("tbl_out_last", 64'(out_if.last), 64'(tbl[n].olast));
            @(posedge clk);
            #1;
        end

        // Steady push+pop at count==1, 20 beats, wrapping the array twice.
        cyc(1'b1, 32'h100, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 20; k++) cyc(1'b1, 32'(32'h101 + k), 1'b1, 1'b1, 1'b0);
        drain();

        // At full, push+pop attempt is pop only.
        for (int k = 0; k < 8; k++) cyc(1'b1, 32'(32'h200 + k), 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 32'h2FF, 1'b1, 1'b1, 1'b0);
        chk("full_pop_count", 64'(count), 64'd7);
        drain();

        // Backpressure with in_valid held for 32 beats.
        idx   = 0;
        stall = 1'b0;
        prev  = '0;
        for (int k = 0; k < 400 && idx < 32; k++) begin
            if (stall) chk("stall_stable", out_if.stream, prev);
            acc   = mq.size() < DEPTH;
            ordy  = 1'($urandom_range(0, 1));
            stall = mvalid_f() && !ordy;
            prev  = out_if.stream;
            cyc(1'b1, 32'(32'h300 + idx), (idx % 4) == 3, ordy, 1'b0);
            if (acc) idx++;
        end
        chk("bp_sent", 64'(idx), 64'd32);
        drain();

        // Flush at count 5 with a beat offered in the same cycle.
        for (int k = 0; k < 5; k++) cyc(1'b1, 32'(32'h400 + k), 1'b0, 1'b0, 1'b0);
        chk("pre_flush_count", 64'(count), 64'd5);
        cyc(1'b1, 32'hEE, 1'b1, 1'b0, 1'b1);
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_empty", 64'(empty), 64'd1);
        chk("flush_in_ready", 64'(in_if.ready), 64'd1);
        cyc(1'b1, 32'hA, 1'b1, 1'b0, 1'b0);
        chk("post_flush_head", out_if.stream, mk(32'hA));
        chk("post_flush_valid", 64'(out_if.valid), 64'd1);
        drain();

        // Reset in the middle of a packet.
        for (int k = 0; k < 3; k++) cyc(1'b1, 32'(32'h500 + k), 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        mq.delete();
        mpkt = 0;
        in_if.valid = 1'b0;
        chk("midrst_count", 64'(count), 64'd0);
        chk("midrst_out_valid", 64'(out_if.valid), 64'd0);
        chk("midrst_out_stream", out_if.stream, 64'd0);
        chk("midrst_in_ready", 64'(in_if.ready), 64'd1);

`ifdef AXIS_PACKET_MODE_EN
        // Store-and-forward: held until the last beat lands.
        cyc(1'b1, 32'h31, 1'b0, 1'b0, 1'b0);
        chk("pkt3_hold1", 64'(out_if.valid), 64'd0);
        cyc(1'b1, 32'h32, 1'b0, 1'b0, 1'b0);
        chk("pkt3_hold2", 64'(out_if.valid), 64'd0);
        cyc(1'b1, 32'h33, 1'b1, 1'b0, 1'b0);
        chk("pkt3_release", 64'(out_if.valid), 64'd1);
        drain();

        // 10-beat packet in an 8-deep FIFO releases at full.
        for (int k = 0; k < 8; k++) cyc(1'b1, 32'(32'h40 + k), 1'b0, 1'b0, 1'b0);
        chk("pkt10_full_valid", 64'(out_if.valid), 64'd1);
        idx = 8;
        for (int k = 0; k < 40 && idx < 10; k++) begin
            acc = mq.size() < DEPTH;
            cyc(1'b1, 32'(32'h40 + idx), idx == 9, 1'b1, 1'b0);
            if (acc) idx++;
        end
        chk("pkt10_sent", 64'(idx), 64'd10);
        drain();
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
